// File: rtl/hamming_secded_encoder_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hamming_secded_encoder_top                                               |
// | Registered extended Hamming(16,11) SEC-DED encoder for a narrow word.    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module hamming_secded_encoder_top #(
  parameter  int DATA_W = 6,
  localparam int CW_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in,
  output logic [CW_W-1:0]   out
);

  localparam int C_K = 11;

  logic [DATA_W-1:0] r_in_q;
  logic [CW_W-1:0]   r_out;
  logic [C_K-1:0]    w_d;
  logic [CW_W-1:0]   w_cw;

  // Data bits beyond DATA_W are tied low so the code stays a valid (16,11) word.
  for (genvar i = 0; i < C_K; i++) begin : g_data
    if (i < DATA_W) begin : g_used
      assign w_d[i] = r_in_q[i];
    end else begin : g_tied
      assign w_d[i] = 1'b0;
    end
  end

  // w_cw[p-1] holds Hamming position p; w_cw[15] is the overall parity.
  always_comb begin
    w_cw     = '0;
    w_cw[2]  = w_d[0];
    w_cw[4]  = w_d[1];
    w_cw[5]  = w_d[2];
    w_cw[6]  = w_d[3];
    w_cw[8]  = w_d[4];
    w_cw[9]  = w_d[5];
    w_cw[10] = w_d[6];
    w_cw[11] = w_d[7];
    w_cw[12] = w_d[8];
    w_cw[13] = w_d[9];
    w_cw[14] = w_d[10];
    w_cw[0]  = w_cw[2] ^ w_cw[4] ^ w_cw[6] ^ w_cw[8] ^ w_cw[10] ^ w_cw[12] ^ w_cw[14];
    w_cw[1]  = w_cw[2] ^ w_cw[5] ^ w_cw[6] ^ w_cw[9] ^ w_cw[10] ^ w_cw[13] ^ w_cw[14];
    w_cw[3]  = w_cw[4] ^ w_cw[5] ^ w_cw[6] ^ w_cw[11] ^ w_cw[12] ^ w_cw[13] ^ w_cw[14];
    w_cw[7]  = w_cw[8] ^ w_cw[9] ^ w_cw[10] ^ w_cw[11] ^ w_cw[12] ^ w_cw[13] ^ w_cw[14];
    w_cw[15] = ^w_cw[14:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_q <= '0;
      r_out  <= '0;
    end else begin
      r_in_q <= in;
      r_out  <= w_cw;
    end
  end

  assign out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_encoder_top.sv
`default_nettype none
// Scoreboard bench for hamming_secded_encoder_top: expected codewords are
// queued when a word is driven and compared when it is due at the output.
module tb_hamming_secded_encoder_top;

  logic        clk;
  logic        rst_n;
  logic [5:0]  in;
  logic [15:0] out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [15:0] exp_q[$];
  int          due_q[$];
  logic [5:0]  src_q[$];

  hamming_secded_encoder_top #(.DATA_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .out   (out)
  );

  initial clk = 1'b0;
  always #100 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dpos(input int k);
    int t[11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    return t[k];
  endfunction

  function automatic logic [15:0] model(input logic [5:0] v);
    logic [15:0] c;
    logic [10:0] d;
    logic        par;
    c = '0;
    d = {5'b0, v};
    for (int k = 0; k < 11; k++) c[dpos(k)-1] = d[k];
    for (int b = 0; b < 4; b++) begin
      par = 1'b0;
      for (int p = 1; p < 16; p++)
        if (((p >> b) & 1) == 1 && (p & (p - 1)) != 0) par = par ^ c[p-1];
      c[(1 << b) - 1] = par;
    end
    c[15] = ^c[14:0];
    return c;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in = 6'b000001;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out !== 16'h8007) begin
      failures++;
      $display("FAIL reset_preload out=%h expected=%h", out, 16'h8007);
    end
    #50;
    in    = 'x;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_async out=%h expected=%h", out, 16'h0000);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_hold out=%h expected=%h", out, 16'h0000);
    end
    @(negedge clk);
    in    = 6'b000000;
    rst_n = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out !== 16'h0000) begin
        failures++;
        $display("FAIL reset_release_e%0d out=%h expected=%h", e, out, 16'h0000);
      end
    end
  endtask

  task automatic test_vector(input logic [5:0] v, input logic [15:0] golden, input string nm);
    @(negedge clk);
    in = v;
    exp_q.push_back(golden); due_q.push_back(cyc + 2); src_q.push_back(v);
    exp_q.push_back(golden); due_q.push_back(cyc + 3); src_q.push_back(v);
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      #1;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        checks++;
        if (out !== exp_q[0] || out !== model(src_q[0])) begin
          failures++;
          $display("FAIL %s out=%h expected=%h", nm, out, exp_q[0]);
        end
        void'(exp_q.pop_front()); void'(due_q.pop_front()); void'(src_q.pop_front());
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d expected=0", nm, exp_q.size());
      exp_q.delete(); due_q.delete(); src_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  vs[2] = '{6'b000001, 6'b111111};
    logic [15:0] gs[2] = '{16'h8007, 16'h837C};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 2) begin
        in = vs[i];
        exp_q.push_back(gs[i]); due_q.push_back(cyc + 2); src_q.push_back(vs[i]);
      end
      @(posedge clk);
      #1;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        checks++;
        if (out !== exp_q[0]) begin
          failures++;
          $display("FAIL back_to_back in=%b out=%h expected=%h", src_q[0], out, exp_q[0]);
        end
        void'(exp_q.pop_front()); void'(due_q.pop_front()); void'(src_q.pop_front());
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL back_to_back_drain pending=%0d expected=0", exp_q.size());
      exp_q.delete(); due_q.delete(); src_q.delete();
    end
  endtask

  task automatic test_sweep();
    int          syn;
    logic [10:0] rec;
    for (int i = 0; i < 66; i++) begin
      @(negedge clk);
      if (i < 64) begin
        in = 6'(i);
        exp_q.push_back(model(6'(i))); due_q.push_back(cyc + 2); src_q.push_back(6'(i));
      end
      @(posedge clk);
      #1;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        syn = 0;
        for (int p = 1; p < 16; p++) if (out[p-1] === 1'b1) syn = syn ^ p;
        for (int k = 0; k < 11; k++) rec[k] = out[dpos(k)-1];
        checks++;
        if (out !== exp_q[0]) begin
          failures++;
          $display("FAIL sweep_model in=%b out=%h expected=%h", src_q[0], out, exp_q[0]);
        end
        checks++;
        if (syn != 0) begin
          failures++;
          $display("FAIL sweep_syndrome in=%b syndrome=%0d expected=0", src_q[0], syn);
        end
        checks++;
        if ((^out) !== 1'b0) begin
          failures++;
          $display("FAIL sweep_parity in=%b out=%h parity=%b expected=0", src_q[0], out, ^out);
        end
        checks++;
        if (out[14:10] !== 5'b0) begin
          failures++;
          $display("FAIL sweep_zero_field in=%b out14_10=%b expected=00000", src_q[0], out[14:10]);
        end
        checks++;
        if (rec !== {5'b0, src_q[0]}) begin
          failures++;
          $display("FAIL sweep_decode out=%h decoded=%h expected=%h", out, rec, {5'b0, src_q[0]});
        end
        void'(exp_q.pop_front()); void'(due_q.pop_front()); void'(src_q.pop_front());
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sweep_drain pending=%0d expected=0", exp_q.size());
      exp_q.delete(); due_q.delete(); src_q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in    = '0;
    test_reset();
    test_vector(6'b101000, 16'h82C9, "vec_101000");
    test_vector(6'b000001, 16'h8007, "vec_000001");
    test_vector(6'b111111, 16'h837C, "vec_111111");
    test_back_to_back();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hamming_secded_encoder_top.md
Name: hamming_secded_encoder_top

Overview:
- Clocked SEC-DED encoder: a 6-bit data word is zero-extended to 11 bits and encoded as an extended Hamming(16,11) codeword (Hamming(15,11) plus an overall parity bit).
- Top-level wrapper: an input capture register, a combinational encoder, and an output register.
- Feeds downstream storage/transmit logic that requires single-error correction and double-error detection.

Parameters:
- DATA_W, 6, width of the input data word; requirement: DATA_W <= 11, unused data positions are tied to 0.
- CW_W, 16, codeword width; fixed at 16, not user-changeable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  6  data word to encode.
- out  output  16  registered SEC-DED codeword.

Behaviour:
- Reset: rst_n low clears the input register and `out` to 16'h0000 immediately, without waiting for a clock edge. Release is synchronous to the next clk rising edge.
- Pipeline:
  - Edge k: `in` is captured into in_q.
  - Edge k+1: `out` is loaded with encode(in_q).
  - Latency is 2 rising edges from `in` to `out`; throughput is one word per cycle.
  - A held `in` gives a stable `out` from the 2nd edge onward.
- Data mapping: d[10:0] = {5'b0, in}. Hamming position p (1..15) maps to out[p-1].
- Data positions: 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15 carry d0..d10 in that order. in[0] goes to position 3 and in[5] goes to position 10; positions 11–15 are always 0.
- Parity bits (even parity):
  - Position 1 = XOR of data at positions with bit0 set (3, 5, 7, 9, 11, 13, 15).
  - Position 2 = XOR over positions with bit1 set (3, 6, 7, 10, 11, 14, 15).
  - Position 4 = XOR over positions with bit2 set (5, 6, 7, 12, 13, 14, 15).
  - Position 8 = XOR over positions 9–15.
- Overall parity: out[15] = XOR of out[14:0], so the full 16-bit word has even parity.
- Invariant: out[14:10] = 0 for all inputs.
- Reset mid-stream: in-flight data is discarded. The first valid output after release appears 2 edges after release with `in` stable.
- X on `in` must not propagate past reset. `out` is driven only from flops, with no combinational path from `in` to `out`.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with out nonzero -> out=16'h0000 immediately; after release, in=6'b000000 -> out stays 16'h0000.
- in=6'b101000, held (clk period 200 ns) -> out=16'h82C9 from the 2nd rising edge after apply.
- in=6'b000001 -> out=16'h8007.
- in=6'b111111 -> out=16'h837C.
- Back-to-back words 6'b000001 then 6'b111111 on consecutive edges -> out=16'h8007 then 16'h837C on consecutive edges, 2-edge latency.
- Exhaustive sweep of all 64 inputs -> syndrome of each out = 0, popcount(out) even, out[14:10]=0, and decoding data positions recovers `in`.
